// File: rtl/pooling_pkg.sv
// Shared types and sizing helpers for the streaming pooling engine.
// Optional average datapath is controlled by POOL_AVG_EN (see pool_lane / pooling_unit).
package pooling_pkg;

  typedef enum logic [1:0] {
    POOL_MAX  = 2'd0,
    POOL_MIN  = 2'd1,
    POOL_AVG  = 2'd2,
    POOL_RSVD = 2'd3
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } pool_state_e;

  // Accumulator width needed to sum WINDOW signed DW-bit words without overflow.
  function automatic int acc_width(input int dw, input int window);
    return dw + $clog2(window);
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling lane: combine/accumulate register plus result register loaded on the last beat.
// With POOL_AVG_EN defined, AW > DW holds the running sum and the result is the floored mean.
module pool_lane
  import pooling_pkg::*;
#(
  parameter int DW = 20,
  parameter int AW = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 update_i,
  input  logic                 last_i,
  input  pool_mode_e           mode_i,
  input  logic signed [DW-1:0] din_i,
  output logic signed [DW-1:0] res_o
);

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] din_x;
  logic signed [AW-1:0] comb;
  logic signed [DW-1:0] res_q, res_d;

  assign din_x = AW'(din_i);

  // Reserved mode (and avg when the avg datapath is absent) fall through to max.
  always_comb begin
    comb = acc_q;
    case (mode_i)
      POOL_MIN: if (din_x < acc_q) comb = din_x;
`ifdef POOL_AVG_EN
      POOL_AVG: comb = acc_q + din_x;
`endif
      default:  if (din_x > acc_q) comb = din_x;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = din_x;
    end else if (update_i) begin
      acc_d = comb;
    end
  end

`ifdef POOL_AVG_EN
  localparam int SH = AW - DW;

  // The sum of WINDOW DW-bit words shifted back by log2(WINDOW) always fits in DW bits.
  always_comb begin
    res_d = res_q;
    if (last_i) begin
      if (mode_i == POOL_AVG) begin
        res_d = DW'(acc_d >>> SH);
      end else begin
        res_d = DW'(acc_d);
      end
    end
  end
`else
  always_comb begin
    res_d = res_q;
    if (last_i) begin
      res_d = DW'(acc_d);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/pooling_unit.sv
// Streaming max/min(/avg with POOL_AVG_EN) pooling over WINDOW beats on CHANNELS lanes.
// Result valid one cycle after the last accepted beat; input stalls while a result is pending.
module pooling_unit
  import pooling_pkg::*;
#(
  parameter int IL       = 4,
  parameter int FL       = 16,
  parameter int CHANNELS = 4,
  parameter int WINDOW   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IL+FL-1:0] in_data  [CHANNELS],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [IL+FL-1:0] out_data [CHANNELS],
  output logic                    busy
);

  localparam int DW = IL + FL;
  localparam int CW = $clog2(WINDOW) + 1;
`ifdef POOL_AVG_EN
  localparam int AW = acc_width(DW, WINDOW);
`else
  localparam int AW = DW;
`endif

  if (WINDOW < 1 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
    $error("pooling_unit: WINDOW must be a power of two and >= 1");
  end

  pool_state_e   state_q, state_d;
  pool_mode_e    mode_q, mode_d;
  logic [CW-1:0] count_q, count_d;

  logic          accept;
  logic          lane_load;
  logic          lane_update;
  logic          lane_last;
  pool_mode_e    lane_mode;

  assign in_ready  = (state_q != OUT);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    count_d     = count_q;
    lane_load   = 1'b0;
    lane_update = 1'b0;
    lane_last   = 1'b0;
    lane_mode   = mode_q;
    case (state_q)
      IDLE: begin
        // The first beat's mode governs the whole window.
        lane_mode = pool_mode_e'(mode);
        if (accept) begin
          lane_load = 1'b1;
          mode_d    = pool_mode_e'(mode);
          count_d   = CW'(1);
          if (WINDOW == 1) begin
            lane_last = 1'b1;
            state_d   = OUT;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          lane_update = 1'b1;
          count_d     = count_q + CW'(1);
          if (count_q == CW'(WINDOW - 1)) begin
            lane_last = 1'b1;
            state_d   = OUT;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= POOL_MAX;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool_lane #(
      .DW (DW),
      .AW (AW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load_i   (lane_load),
      .update_i (lane_update),
      .last_i   (lane_last),
      .mode_i   (lane_mode),
      .din_i    (in_data[c]),
      .res_o    (out_data[c])
    );
  end

endmodule

// File: tb/tb_pooling_unit.sv
// Directed self-checking bench for pooling_unit (IL=4, FL=16, CHANNELS=4, WINDOW=4).
// Avg expectations follow POOL_AVG_EN; without it mode 2 is expected to act as max.
module tb_pooling_unit;

  localparam int DW = 20;
  localparam int CH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           mode = 2'd0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data [CH];
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] out_data [CH];
  logic                 busy;

  int n_pass  = 0;
  int n_total = 0;

  pooling_unit #(
    .IL       (4),
    .FL       (16),
    .CHANNELS (CH),
    .WINDOW   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offer one beat and return #1 after the edge that accepted it.
  task automatic send(input logic [DW-1:0] a, b, c, d, input logic [1:0] m);
    int n;
    in_data[0] = a; in_data[1] = b; in_data[2] = c; in_data[3] = d;
    mode = m;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      n_total++;
      $display("FAIL take_timeout out_valid=%0b required 1", out_valid);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_data[0] = '0; in_data[1] = '0; in_data[2] = '0; in_data[3] = '0;
    do_reset();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else n_pass++;
    for (int c = 0; c < CH; c++) begin
      n_total++;
      if (out_data[c] !== 20'h0) $display("FAIL reset_out_data[%0d] got %h want 00000", c, out_data[c]);
      else n_pass++;
    end
  endtask

  task automatic test_max();
    logic [DW-1:0] exp [CH];
    exp = '{20'h38000, 20'hF0000, 20'h00009, 20'h7FFFF};
    send(20'h10000, 20'hF0000, 20'h00005, 20'h7FFFF, 2'd0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL max_busy got %0b want 1", busy); else n_pass++;
    send(20'hE0000, 20'hF0000, 20'h00003, 20'h80000, 2'd0);
    send(20'h38000, 20'hF0000, 20'h00009, 20'h00000, 2'd0);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL max_early_valid got %0b want 0", out_valid); else n_pass++;
    send(20'h04000, 20'hF0000, 20'h00002, 20'h00001, 2'd0);
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL max_latency out_valid got %0b want 1", out_valid); else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL max_in_ready_out got %0b want 0", in_ready); else n_pass++;
    for (int c = 0; c < CH; c++) begin
      n_total++;
      if (out_data[c] !== exp[c]) $display("FAIL max_lane%0d got %h want %h", c, out_data[c], exp[c]);
      else n_pass++;
    end
    take();
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL max_after_take out_valid=%0b busy=%0b want 0 0", out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_min();
    logic [DW-1:0] exp [CH];
    exp = '{20'hF0000, 20'h00003, 20'h80000, 20'hFFFFB};
    send(20'h10000, 20'h00003, 20'h80000, 20'h00005, 2'd1);
    send(20'hF0000, 20'h00003, 20'h7FFFF, 20'hFFFFB, 2'd1);
    send(20'h20000, 20'h00003, 20'h00000, 20'h00000, 2'd1);
    send(20'h08000, 20'h00003, 20'h00001, 20'h00002, 2'd1);
    for (int c = 0; c < CH; c++) begin
      n_total++;
      if (out_data[c] !== exp[c]) $display("FAIL min_lane%0d got %h want %h", c, out_data[c], exp[c]);
      else n_pass++;
    end
    take();
  endtask

  task automatic test_avg();
    logic [DW-1:0] exp [CH];
`ifdef POOL_AVG_EN
    exp = '{20'h2C000, 20'hFFFFF, 20'h7FFFF, 20'h80000};
`else
    exp = '{20'h50000, 20'h00000, 20'h7FFFF, 20'h80000};
`endif
    send(20'h10000, 20'hFFFFF, 20'h7FFFF, 20'h80000, 2'd2);
    send(20'h20000, 20'h00000, 20'h7FFFF, 20'h80000, 2'd2);
    send(20'h30000, 20'h00000, 20'h7FFFF, 20'h80000, 2'd2);
    send(20'h50000, 20'h00000, 20'h7FFFF, 20'h80000, 2'd2);
    for (int c = 0; c < CH; c++) begin
      n_total++;
      if (out_data[c] !== exp[c]) $display("FAIL avg_lane%0d got %h want %h", c, out_data[c], exp[c]);
      else n_pass++;
    end
    take();
  endtask

  // Reserved mode with 3-cycle input gaps: same vectors and result as the max window.
  task automatic test_gaps_rsvd();
    logic [DW-1:0] exp [CH];
    exp = '{20'h38000, 20'hF0000, 20'h00009, 20'h7FFFF};
    send(20'h10000, 20'hF0000, 20'h00005, 20'h7FFFF, 2'd3);
    repeat (3) tick();
    send(20'hE0000, 20'hF0000, 20'h00003, 20'h80000, 2'd3);
    repeat (3) tick();
    n_total++;
    if (busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL gap_hold busy=%0b out_valid=%0b want 1 0", busy, out_valid);
    else n_pass++;
    send(20'h38000, 20'hF0000, 20'h00009, 20'h00000, 2'd3);
    repeat (3) tick();
    send(20'h04000, 20'hF0000, 20'h00002, 20'h00001, 2'd3);
    for (int c = 0; c < CH; c++) begin
      n_total++;
      if (out_data[c] !== exp[c]) $display("FAIL gap_lane%0d got %h want %h", c, out_data[c], exp[c]);
      else n_pass++;
    end
    take();
  endtask

  task automatic test_out_backpressure();
    send(20'h00001, 20'h00001, 20'h00001, 20'h00001, 2'd0);
    send(20'h00002, 20'h00002, 20'h00002, 20'h00002, 2'd0);
    send(20'h00003, 20'h00003, 20'h00003, 20'h00003, 2'd0);
    send(20'h00004, 20'h00004, 20'h00004, 20'h00004, 2'd0);
    // Next window's first beat is offered during the stall and must survive it.
    in_data[0] = 20'h00050; in_data[1] = 20'h00050; in_data[2] = 20'h00050; in_data[3] = 20'h00050;
    mode = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data[0] !== 20'h00004)
        $display("FAIL stall_cycle%0d out_valid=%0b in_ready=%0b data=%h want 1 0 00004",
                 i, out_valid, in_ready, out_data[0]);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_release out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL stall_beat_taken busy=%0b want 1", busy); else n_pass++;
    send(20'h00001, 20'h00001, 20'h00001, 20'h00001, 2'd0);
    send(20'h00001, 20'h00001, 20'h00001, 20'h00001, 2'd0);
    send(20'h00001, 20'h00001, 20'h00001, 20'h00001, 2'd0);
    for (int c = 0; c < CH; c++) begin
      n_total++;
      if (out_data[c] !== 20'h00050) $display("FAIL stall_next_lane%0d got %h want 00050", c, out_data[c]);
      else n_pass++;
    end
    take();
  endtask

  task automatic test_mode_sampling();
    logic [DW-1:0] exp [CH];
    exp = '{20'h00001, 20'hF0000, 20'h00001, 20'h00001};
    send(20'h00005, 20'hF0000, 20'h00005, 20'h00005, 2'd1);
    send(20'h00009, 20'h10000, 20'h00009, 20'h00009, 2'd0);
    send(20'h00001, 20'h10000, 20'h00001, 20'h00001, 2'd0);
    send(20'h00007, 20'h10000, 20'h00007, 20'h00007, 2'd0);
    for (int c = 0; c < CH; c++) begin
      n_total++;
      if (out_data[c] !== exp[c]) $display("FAIL modesamp_lane%0d got %h want %h", c, out_data[c], exp[c]);
      else n_pass++;
    end
    take();
  endtask

  task automatic test_reset_mid();
    send(20'h00064, 20'h00064, 20'h00064, 20'h00064, 2'd0);
    send(20'h00064, 20'h00064, 20'h00064, 20'h00064, 2'd0);
    do_reset();
    n_total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrst_state busy=%0b out_valid=%0b in_ready=%0b want 0 0 1",
               busy, out_valid, in_ready);
    else n_pass++;
    send(20'h00007, 20'h00007, 20'h00007, 20'h00007, 2'd0);
    send(20'h00001, 20'h00001, 20'h00001, 20'h00001, 2'd0);
    send(20'h00001, 20'h00001, 20'h00001, 20'h00001, 2'd0);
    send(20'h00001, 20'h00001, 20'h00001, 20'h00001, 2'd0);
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL midrst_valid got %0b want 1", out_valid); else n_pass++;
    for (int c = 0; c < CH; c++) begin
      n_total++;
      if (out_data[c] !== 20'h00007) $display("FAIL midrst_lane%0d got %h want 00007", c, out_data[c]);
      else n_pass++;
    end
    // Reset while a result is pending drops it.
    do_reset();
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_pending out_valid=%0b busy=%0b want 0 0", out_valid, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_max();
    test_min();
    test_avg();
    test_gaps_rsvd();
    test_out_backpressure();
    test_mode_sampling();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
